// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mem_pkg
// Description : Shared types and defaults for the memory access controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Controller phases for one core memory access
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int unsigned c_tw_default      = 8;
  localparam int unsigned c_timeout_default = 255;
  localparam logic [31:0] c_err_data_default = 32'hDEAD_BEEF;

  // Drop the byte offset so memory always sees a word address
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface   : mem_access_ctrl_if
// Description : req/ack bus between the access controller and unified memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  // Controller side issues requests
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  // Memory side answers them
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : wait_timer
// Description : Wait-cycle counter with clear/enable; terminal count flags the
//               cycle whose increment would reach TIMEOUT.
// Revision    : 1.0 - initial release
// ============================================================================
module wait_timer #(
  parameter int unsigned TW      = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_clr,
  input  wire logic i_en,
  output logic      o_tc
);

  // Count value seen in the last allowed waiting cycle
  localparam logic [TW-1:0] c_last = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_count;

  // Count waiting cycles; clear takes priority over enable
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + TW'(1);
    end
  end

  // Kept independent of i_en so the controller's decode has no loop through it
  assign o_tc = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Turns the multicycle core's single-cycle memory port into a
//               req/ack handshake, stalling the core while an access is open,
//               holding read data and flagging misaligned/timed-out accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT  = c_timeout_default,
  parameter int unsigned TW       = c_tw_default,
  parameter logic [31:0] ERR_DATA = c_err_data_default
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic [31:0] Adr,
  input  wire logic [31:0] WriteData,
  input  wire logic        MemRead,
  input  wire logic        MemWrite,
  output logic [31:0]      ReadData,
  output logic             Stall,
  output logic             BusErr,
  mem_access_ctrl_if.master mem
);

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [31:0] r_read_data;
  logic        r_bus_err;

  logic        w_acc;
  logic        w_aligned;
  logic        w_latch;
  logic        w_tmr_clr;
  logic        w_tmr_en;
  logic        w_tc;
  logic        w_rd_load;
  logic [31:0] w_rd_val;
  logic        w_set_err;

  // A simultaneous read and write request is treated as a write
  assign w_acc     = MemRead | MemWrite;
  assign w_aligned = (Adr[1:0] == 2'b00);

  wait_timer #(
    .TW      (TW),
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_tmr_clr),
    .i_en  (w_tmr_en),
    .o_tc  (w_tc)
  );

  // State register; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus stall, latch and read-data load controls
  always_comb begin
    w_next    = r_state;
    Stall     = 1'b0;
    w_latch   = 1'b0;
    w_tmr_clr = 1'b0;
    w_tmr_en  = 1'b0;
    w_rd_load = 1'b0;
    w_rd_val  = r_read_data;
    w_set_err = 1'b0;
    case (r_state)
      IDLE: begin
        Stall     = w_acc;
        w_tmr_clr = 1'b1;
        if (w_acc) begin
          if (w_aligned) begin
            w_latch = 1'b1;
            w_next  = REQ;
          end else begin
            // Misaligned: never reaches memory, reported one cycle later
            w_set_err = 1'b1;
            w_next    = DONE;
            if (!MemWrite) begin
              w_rd_load = 1'b1;
              w_rd_val  = ERR_DATA;
            end
          end
        end
      end
      REQ: begin
        Stall    = 1'b1;
        w_tmr_en = 1'b1;
        // Ack is checked first so it beats a timeout in the same cycle
        if (mem.mem_ack) begin
          w_next = DONE;
          if (!r_we) begin
            w_rd_load = 1'b1;
            w_rd_val  = mem.mem_rdata;
          end
        end else if (w_tc) begin
          w_set_err = 1'b1;
          w_next    = DONE;
          if (!r_we) begin
            w_rd_load = 1'b1;
            w_rd_val  = ERR_DATA;
          end
        end
      end
      DONE: begin
        // The core still shows the finished request here, so it is ignored
        w_tmr_clr = 1'b1;
        w_next    = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Latch the request so address/data/direction stay stable through REQ
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else if (w_latch) begin
      r_addr  <= word_align(Adr);
      r_wdata <= WriteData;
      r_we    <= MemWrite;
    end
  end

  // Read data holds until the next read completes; error flag lives for DONE only
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_read_data <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      r_bus_err <= w_set_err;
      if (w_rd_load) begin
        r_read_data <= w_rd_val;
      end
    end
  end

  assign ReadData      = r_read_data;
  assign BusErr        = r_bus_err;
  assign mem.mem_req   = (r_state == REQ);
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sits directly downstream of the multicycle datapath's memory port (Adr / WriteData / ReadData).
- Converts the core's single-cycle memory access into a req/ack handshake toward a variable-latency unified instruction/data memory.
- Asserts Stall so the main controller freezes its state while an access is outstanding.
- Holds the returned word stable for the instruction register and data register, and flags misaligned or timed-out accesses.

Parameters:
- TIMEOUT, 255: max cycles in REQ without mem_ack before the access aborts with a bus error.
- TW, 8: width of the wait counter; TIMEOUT must be < 2**TW.
- ERR_DATA, 32'hDEAD_BEEF: value loaded into ReadData on an aborted read.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- Adr  in  32  byte address from the datapath address mux
- WriteData  in  32  store data from the datapath
- MemRead  in  1  core read request (fetch or load), level, held while Stall
- MemWrite  in  1  core write request, level, held while Stall
- ReadData  out  32  registered read data to instruction and data registers
- Stall  out  1  freeze controller/datapath enables this cycle
- BusErr  out  1  high only in the DONE cycle of a failed access
- mem_req  out  1  request to memory
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address, latched
- mem_wdata  out  32  latched store data
- mem_rdata  in  32  memory read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion strobe

Behaviour:
- Reset (reset==0 at posedge):
  - State goes to IDLE.
  - ReadData=0, BusErr=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counter=0.
  - Reset mid-access abandons the access. An mem_ack arriving after reset is ignored.
- Definitions: acc = MemRead|MemWrite. If both are high, it is a write.
- IDLE:
  - Stall = acc (combinational).
  - On acc with Adr[1:0]==0: latch addr/data/we and go to REQ.
  - On acc with Adr[1:0]!=0: no external request. Load ReadData=ERR_DATA if a read, and go to DONE with err flag set.
- REQ:
  - mem_req=1. mem_addr, mem_wdata and mem_we stay stable until the cycle after ack. Stall=1. Counter increments each cycle.
  - On mem_ack: go to DONE. If a read, ReadData<=mem_rdata. A write leaves ReadData unchanged.
  - If the counter reaches TIMEOUT without ack: go to DONE with err. If a read, ReadData<=ERR_DATA.
  - If ack and timeout occur in the same cycle, ack wins with no error.
- DONE (exactly 1 cycle):
  - Stall=0 and BusErr=err, so the controller advances at the end of this cycle.
  - acc is ignored in DONE, because the core still presents the old request.
  - Counter clears. Next state is IDLE.
- mem_ack outside REQ is ignored.
- Latency: acc seen in cycle 0, REQ in cycle 1, ack at the earliest in cycle 1, DONE in cycle 2. Minimum 2 stall cycles; k-cycle memory gives k+1.
- ReadData holds its last value until the next read completes. It is valid throughout DONE, when IRWrite/datareg sample it.
- mem_addr is output as {Adr[31:2],2'b00}.

Decomposition:
- Shared package mem_pkg:
  - typedef enum for state: IDLE, REQ, DONE.
  - ERR_DATA default constant.
  - TW default.
- One natural sub-module: wait_timer (TW-bit counter with clear/enable and terminal-count output). Everything else stays in mem_access_ctrl.

Test Plan:
- Read, 0-wait: MemRead, Adr=0x100, ack with rdata=0xE3A0_1005 in the first REQ cycle -> Stall high for 2 cycles. mem_addr=0x100, mem_we=0. ReadData=0xE3A0_1005 in DONE, BusErr=0.
- Write, 3-wait: MemWrite, Adr=0x200, WriteData=0x1234_5678, ack 3 cycles into REQ -> mem_req held 3 cycles with stable addr/data and mem_we=1. Stall for 4 cycles. ReadData unchanged.
- Misaligned: MemRead with Adr=0x102 -> mem_req never asserts. Next cycle is DONE with BusErr=1 and ReadData=0xDEAD_BEEF.
- Timeout: TIMEOUT=4, no ack -> DONE after 4 REQ cycles with BusErr=1. A late ack is ignored and ReadData stays ERR_DATA.
- Back-to-back: the request is still asserted in DONE and then changes to a new Adr -> no double access. The second access starts from IDLE in the cycle after DONE.
- Reset mid-REQ: reset=0 in REQ cycle 2 -> mem_req=0 and all outputs reset next cycle. An ack in the following cycle has no effect.
